// File: rtl/uart_pkg.sv
// Shared definitions for the UART bus controller: register map, CON bit
// positions and the TX sequencer state encoding.
package uart_pkg;

    localparam logic [31:0] ADDR_TXD = 32'h4000_0018;
    localparam logic [31:0] ADDR_RXD = 32'h4000_001C;
    localparam logic [31:0] ADDR_CON = 32'h4000_0020;

    localparam int CON_TX_INT_EN  = 0;
    localparam int CON_RX_INT_EN  = 1;
    localparam int CON_TX_DONE    = 2;
    localparam int CON_RX_VALID   = 3;
    localparam int CON_TX_BUSY    = 4;
    localparam int CON_TX_FULL    = 5;
    localparam int CON_RX_OVERRUN = 6;
    localparam int CON_TX_DROP    = 7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        BUSY = 2'd2
    } tx_state_e;

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding the UART sender; push is ignored when full and pop when
// empty, so the caller may assert both freely.
module uart_tx_fifo #(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          sysclk,
    input  logic          reset,
    input  logic          push,
    input  logic [7:0]    din,
    input  logic          pop,
    output logic [7:0]    head,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (!do_push && do_pop) count <= count - 1'b1;
        end
    end

    // Storage needs no reset: entries are only read once count says valid.
    always_ff @(posedge sysclk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/uart_ctrl.sv
// Memory-mapped UART controller: TX FIFO plus start/idle sequencer toward the
// sender, RX holding register with valid/overrun flags, and an interrupt.
module uart_ctrl import uart_pkg::*; #(
    parameter  int FIFO_DEPTH  = 4,
    parameter  int ACK_TIMEOUT = 1024,
    localparam int CW          = $clog2(FIFO_DEPTH) + 1,
    localparam int TW          = $clog2(ACK_TIMEOUT)
) (
    input  logic        sysclk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic        mem_rd,
    input  logic        mem_wr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic [7:0]  tx_data,
    output logic        tx_start,
    input  logic        tx_status,
    input  logic [7:0]  rx_data,
    input  logic        rx_status,
    output logic        irq
);

    tx_state_e     state, state_nxt;
    logic [TW-1:0] timer;
    logic          wr_txd, wr_con, rd_rxd, rd_con;
    logic          pop;
    logic [7:0]    fifo_head;
    logic [CW-1:0] fifo_count;
    logic          fifo_empty, fifo_full_unused;
    logic          tx_full, tx_busy;
    logic          tx_int_en, rx_int_en, tx_done, rx_valid, rx_overrun, tx_drop;
    logic [7:0]    rx_hold;
    logic [31:0]   con;
    logic          unused_wdata;

    assign unused_wdata = ^wdata[31:8];

    // A cycle with both strobes counts as a write; the read side effects drop.
    assign wr_txd = mem_wr & (addr == ADDR_TXD);
    assign wr_con = mem_wr & (addr == ADDR_CON);
    assign rd_rxd = mem_rd & ~mem_wr & (addr == ADDR_RXD);
    assign rd_con = mem_rd & ~mem_wr & (addr == ADDR_CON);

    uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .sysclk (sysclk),
        .reset  (reset),
        .push   (wr_txd),
        .din    (wdata[7:0]),
        .pop    (pop),
        .head   (fifo_head),
        .count  (fifo_count),
        .full   (fifo_full_unused),
        .empty  (fifo_empty)
    );

    assign tx_full  = (fifo_count == CW'(FIFO_DEPTH));
    assign tx_busy  = (state != IDLE) | ~fifo_empty;
    assign tx_start = (state == REQ);

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Waiting for tx_status in IDLE keeps us off a sender still shifting a
    // byte started before reset.
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        unique case (state)
            IDLE: if (!fifo_empty && tx_status) state_nxt = REQ;
            REQ: begin
                if (!tx_status)                          state_nxt = BUSY;
                else if (timer == TW'(ACK_TIMEOUT - 1)) state_nxt = IDLE;
            end
            BUSY: if (tx_status) begin
                state_nxt = IDLE;
                pop       = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            timer   <= '0;
            tx_data <= '0;
        end else begin
            timer <= (state == REQ) ? timer + 1'b1 : '0;
            if (state == IDLE && state_nxt == REQ) tx_data <= fifo_head;
        end
    end

    // Sticky flags: a new event in the same cycle as a CON read wins.
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            tx_int_en  <= 1'b0;
            rx_int_en  <= 1'b0;
            tx_done    <= 1'b0;
            tx_drop    <= 1'b0;
            rx_valid   <= 1'b0;
            rx_overrun <= 1'b0;
            rx_hold    <= '0;
            irq        <= 1'b0;
        end else begin
            if (wr_con) {rx_int_en, tx_int_en} <= wdata[1:0];
            tx_done    <= pop | (tx_done & ~rd_con);
            tx_drop    <= (wr_txd & tx_full) | (tx_drop & ~rd_con);
            if (rx_status) rx_hold <= rx_data;
            rx_valid   <= rx_status | (rx_valid & ~rd_rxd);
            rx_overrun <= (rx_status & rx_valid & ~rd_rxd) | (rx_overrun & ~rd_con);
            irq        <= (tx_int_en & tx_done) | (rx_int_en & rx_valid);
        end
    end

    always_comb begin
        con                 = '0;
        con[CON_TX_INT_EN]  = tx_int_en;
        con[CON_RX_INT_EN]  = rx_int_en;
        con[CON_TX_DONE]    = tx_done;
        con[CON_RX_VALID]   = rx_valid;
        con[CON_TX_BUSY]    = tx_busy;
        con[CON_TX_FULL]    = tx_full;
        con[CON_RX_OVERRUN] = rx_overrun;
        con[CON_TX_DROP]    = tx_drop;
    end

    always_comb begin
        rdata = '0;
        if (addr == ADDR_RXD)      rdata = {24'b0, rx_hold};
        else if (addr == ADDR_CON) rdata = con;
    end

endmodule

// File: tb/tb_uart_ctrl.sv
// Scoreboarded bench for uart_ctrl: bus tasks drive registers, a sender model
// acknowledges tx_start and checks each byte against the expected queue.
module tb_uart_ctrl;
    localparam logic [31:0] A_TXD = 32'h4000_0018;
    localparam logic [31:0] A_RXD = 32'h4000_001C;
    localparam logic [31:0] A_CON = 32'h4000_0020;

    logic        sysclk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] addr = '0;
    logic        mem_rd = 1'b0;
    logic        mem_wr = 1'b0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_status = 1'b1;
    logic [7:0]  rx_data = '0;
    logic        rx_status = 1'b0;
    logic        irq;

    int          n_tests = 0;
    int          n_fail = 0;
    logic [7:0]  exp_q[$];
    int          snd_cnt = 0;
    bit          snd_en = 1'b0;
    bit          snd_hold = 1'b0;

    uart_ctrl dut (
        .sysclk(sysclk), .reset(reset), .addr(addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .wdata(wdata), .rdata(rdata), .tx_data(tx_data), .tx_start(tx_start),
        .tx_status(tx_status), .rx_data(rx_data), .rx_status(rx_status), .irq(irq)
    );

    always #5 sysclk = ~sysclk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Sender model: accepts a request, stays busy a few cycles, then goes idle.
    always @(negedge sysclk) begin
        if (snd_cnt > 0) begin
            if (!snd_hold) begin
                snd_cnt--;
                if (snd_cnt == 0) tx_status = 1'b1;
            end
        end else if (snd_en && tx_start && tx_status) begin
            if (exp_q.size() == 0) chk("tx_unexpected", {24'b0, tx_data}, 32'hFFFF_FFFF);
            else                   chk("tx_byte", {24'b0, tx_data}, {24'b0, exp_q.pop_front()});
            tx_status = 1'b0;
            snd_cnt   = 5;
        end
    end

    task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
        addr = a; wdata = d; mem_wr = 1'b1;
        @(negedge sysclk);
        mem_wr = 1'b0;
    endtask

    task automatic bus_rd(input logic [31:0] a, output logic [31:0] d);
        addr = a; mem_rd = 1'b1;
        #1 d = rdata;
        @(negedge sysclk);
        mem_rd = 1'b0;
    endtask

    task automatic rx_pulse(input logic [7:0] d);
        rx_data = d; rx_status = 1'b1;
        @(negedge sysclk);
        rx_status = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        int k, hi, lo;

        // Reset state
        repeat (3) @(negedge sysclk);
        addr = A_CON;
        #1;
        chk("rst_tx_start", {31'b0, tx_start}, 0);
        chk("rst_tx_data", {24'b0, tx_data}, 0);
        chk("rst_irq", {31'b0, irq}, 0);
        chk("rst_con", rdata, 0);
        @(negedge sysclk);
        reset = 1'b1;
        @(negedge sysclk);

        // Single byte: start latency, ack handshake, tx_done
        snd_en = 1'b1;
        exp_q.push_back(8'h55);
        bus_wr(A_TXD, 32'h55);
        chk("t1_start_e1", {31'b0, tx_start}, 0);
        @(negedge sysclk);
        chk("t1_start_e2", {31'b0, tx_start}, 1);
        chk("t1_data", {24'b0, tx_data}, 32'h55);
        @(negedge sysclk);
        chk("t1_start_drop", {31'b0, tx_start}, 0);
        repeat (12) @(negedge sysclk);
        bus_rd(A_CON, d);  chk("t1_con_done", d, 32'h04);
        bus_rd(A_CON, d);  chk("t1_con_clr", d, 32'h00);
        bus_rd(A_TXD, d);  chk("t1_txd_rd", d, 32'h00);

        // Overflow with a stalled sender, then drain in order
        snd_en = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            if (i <= 4) exp_q.push_back(8'(i));
            bus_wr(A_TXD, 32'(i));
        end
        bus_rd(A_CON, d);  chk("t2_con_full", d, 32'hB0);
        snd_en = 1'b1;
        repeat (60) @(negedge sysclk);
        chk("t2_drained", exp_q.size(), 0);
        bus_wr(A_CON, 32'h1);
        repeat (2) @(negedge sysclk);
        chk("t2_irq_tx", {31'b0, irq}, 1);
        bus_rd(A_CON, d);  chk("t2_con_done", d, 32'h05);
        @(negedge sysclk);
        chk("t2_irq_clr", {31'b0, irq}, 0);
        bus_wr(A_CON, 32'h0);

        // RX byte, interrupt, RXD read clears valid
        bus_wr(A_CON, 32'h2);
        rx_pulse(8'hA3);
        @(negedge sysclk);
        chk("t3_irq_rx", {31'b0, irq}, 1);
        bus_rd(A_CON, d);  chk("t3_con_valid", d, 32'h0A);
        addr = 32'h4000_0024;
        #1 chk("t3_unmapped", rdata, 0);
        bus_rd(A_RXD, d);  chk("t3_rxd", d, 32'hA3);
        @(negedge sysclk);
        chk("t3_irq_clr", {31'b0, irq}, 0);
        bus_rd(A_CON, d);  chk("t3_con_clr", d, 32'h02);

        // Overrun, then a pulse coincident with an RXD read
        rx_pulse(8'h11);
        rx_pulse(8'h22);
        bus_rd(A_CON, d);  chk("t4_con_ovr", d, 32'h4A);
        bus_rd(A_RXD, d);  chk("t4_rxd_last", d, 32'h22);
        rx_pulse(8'h33);
        addr = A_RXD; mem_rd = 1'b1; rx_data = 8'h44; rx_status = 1'b1;
        #1 chk("t4_rxd_coinc", rdata, 32'h33);
        @(negedge sysclk);
        mem_rd = 1'b0; rx_status = 1'b0;
        bus_rd(A_CON, d);  chk("t4_con_noovr", d, 32'h0A);
        bus_rd(A_RXD, d);  chk("t4_rxd_new", d, 32'h44);
        bus_wr(A_CON, 32'h0);

        // Ack timeout: request dropped and re-issued, byte retained
        snd_en = 1'b0;
        exp_q.push_back(8'h77);
        bus_wr(A_TXD, 32'h77);
        k = 0;
        while (!tx_start && k < 10) begin @(negedge sysclk); k++; end
        chk("t5_rise", {31'b0, tx_start}, 1);
        hi = 0;
        while (tx_start && hi < 2000) begin @(negedge sysclk); hi++; end
        chk("t5_high_cycles", hi, 1024);
        lo = 0;
        while (!tx_start && lo < 10) begin @(negedge sysclk); lo++; end
        chk("t5_rearm", {31'b0, (lo >= 1 && lo <= 2)}, 1);
        chk("t5_data_kept", {24'b0, tx_data}, 32'h77);
        bus_rd(A_CON, d);  chk("t5_con_busy", d, 32'h10);
        snd_en = 1'b1;
        repeat (20) @(negedge sysclk);
        chk("t5_sent", exp_q.size(), 0);
        bus_rd(A_CON, d);  chk("t5_con_done", d, 32'h04);

        // Reset while the sender is shifting
        snd_hold = 1'b1;
        exp_q.push_back(8'h9C);
        bus_wr(A_TXD, 32'h9C);
        k = 0;
        while (tx_status && k < 20) begin @(negedge sysclk); k++; end
        repeat (2) @(negedge sysclk);
        chk("t6_busy_data", {24'b0, tx_data}, 32'h9C);
        chk("t6_busy_start", {31'b0, tx_start}, 0);
        reset = 1'b0;
        addr = A_CON;
        #1;
        chk("t6_rst_data", {24'b0, tx_data}, 0);
        chk("t6_rst_con", rdata, 0);
        chk("t6_rst_irq", {31'b0, irq}, 0);
        @(negedge sysclk);
        reset = 1'b1;
        exp_q.push_back(8'h5A);
        bus_wr(A_TXD, 32'h5A);
        hi = 0;
        repeat (6) begin @(negedge sysclk); if (tx_start) hi++; end
        chk("t6_no_start", hi, 0);
        snd_hold = 1'b0;
        repeat (30) @(negedge sysclk);
        chk("t6_sent", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
